// File: rtl/z16_instr_loader_if.sv
// Byte-stream and instruction-memory write bus of the Z16 boot loader.
// The slave modport is the loader's view: it sinks the byte stream and
// drives the memory write port. The master modport is the system side.
interface z16_instr_loader_if;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        o_imem_wen;
  logic [15:0] o_imem_addr;
  logic [15:0] o_imem_data;

  modport slave (
    input  i_byte,
    input  i_byte_valid,
    output o_byte_ready,
    output o_imem_wen,
    output o_imem_addr,
    output o_imem_data
  );

  modport master (
    output i_byte,
    output i_byte_valid,
    input  o_byte_ready,
    input  o_imem_wen,
    input  o_imem_addr,
    input  o_imem_data
  );
endinterface

// File: rtl/z16_instr_loader.sv
// Z16 boot loader: receives a length-prefixed, checksummed byte frame,
// writes little-endian instruction words to consecutive even addresses and
// releases the CPU from reset only after the whole image has verified.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_LEN_LO  | waiting for low byte of word count (never times out)
// S_LEN_HI  | waiting for high byte of word count; count is validated
// S_DATA_LO | waiting for low byte of the next instruction word
// S_DATA_HI | waiting for high byte; completes and writes the word
// S_CHECK   | waiting for the checksum byte
// S_DONE    | image verified, CPU released, waits for restart
// S_ERROR   | length/checksum/timeout failure, bytes refused, waits restart
module z16_instr_loader #(
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_restart,
  z16_instr_loader_if.slave bus,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_error
);

  // Idle counter only ever needs to hold TIMEOUT_CYCLES-1 before firing.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_LEN_LO  = 3'd0,
    S_LEN_HI  = 3'd1,
    S_DATA_LO = 3'd2,
    S_DATA_HI = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    lo_q, lo_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   ptr_q, ptr_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          wen_q, wen_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          cpu_rst_q, cpu_rst_d;

  logic          accept;
  logic          timed;
  logic [15:0]   len_full;

  assign accept   = bus.i_byte_valid && ready_q;
  assign len_full = {bus.i_byte, len_q[7:0]};

  // State and output registers; async reset aborts any frame in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_LEN_LO;
      len_q     <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      ptr_q     <= BASE_ADDR;
      addr_q    <= BASE_ADDR;
      data_q    <= '0;
      wen_q     <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wen_q     <= wen_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // Next-state, datapath updates and registered-output decode.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    tmo_d   = tmo_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wen_d   = 1'b0;

    timed = (state_q == S_LEN_HI) || (state_q == S_DATA_LO) ||
            (state_q == S_DATA_HI) || (state_q == S_CHECK);

    // The checksum byte itself is not part of the sum it is compared to.
    if (accept && (state_q != S_CHECK)) begin
      chk_d = chk_q + bus.i_byte;
    end

    if (accept || !timed || !TMO_EN) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = bus.i_byte;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bus.i_byte;
          if ((len_full == 16'd0) || (32'(len_full) > MAX_WORDS)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          lo_d    = bus.i_byte;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          wen_d   = 1'b1;
          data_d  = {bus.i_byte, lo_q};
          addr_d  = ptr_q;
          ptr_d   = ptr_q + 16'd2;
          cnt_d   = cnt_q + 16'd1;
          state_d = (cnt_d == len_q) ? S_CHECK : S_DATA_LO;
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (bus.i_byte == chk_q) ? S_DONE : S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (i_restart) begin
          state_d = S_LEN_LO;
          len_d   = '0;
          lo_d    = '0;
          cnt_d   = '0;
          chk_d   = '0;
          tmo_d   = '0;
          ptr_d   = BASE_ADDR;
          addr_d  = BASE_ADDR;
        end
      end
      default: state_d = S_ERROR;
    endcase

    // An accepted byte in the same cycle always beats the timeout.
    if (TMO_EN && timed && !accept && (tmo_q == TMO_LAST)) begin
      state_d = S_ERROR;
    end

    ready_d   = (state_d != S_DONE) && (state_d != S_ERROR);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERROR);
    cpu_rst_d = (state_d != S_DONE);
  end

  assign bus.o_byte_ready = ready_q;
  assign bus.o_imem_wen   = wen_q;
  assign bus.o_imem_addr  = addr_q;
  assign bus.o_imem_data  = data_q;
  assign o_cpu_rst        = cpu_rst_q;
  assign o_done           = done_q;
  assign o_error          = error_q;

endmodule

// File: tb/tb_z16_instr_loader.sv
// Randomized scoreboard bench for the Z16 instruction loader.
module tb_z16_instr_loader;
  localparam int          MAXW = 8;
  localparam int          TMO  = 16;
  localparam logic [15:0] BASE = 16'h0000;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic restart = 1'b0;
  logic cpu_rst, done, error;

  z16_instr_loader_if bus ();

  always #5 clk = ~clk;

  z16_instr_loader #(
    .BASE_ADDR     (BASE),
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_restart(restart),
    .bus      (bus),
    .o_cpu_rst(cpu_rst),
    .o_done   (done),
    .o_error  (error)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  int         vectors     = 0;
  int         miscompares = 0;
  wr_t        exp_q[$];
  logic [7:0] frm[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected one.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && bus.o_imem_wen !== 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0h data %0h wen %b (t=%0t)",
                 bus.o_imem_addr, bus.o_imem_data, bus.o_imem_wen, $time);
      end else begin
        e = exp_q.pop_front();
        check("imem_addr", 32'(bus.o_imem_addr), 32'(e.addr));
        check("imem_data", 32'(bus.o_imem_data), 32'(e.data));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected below 900000", $time);
    $fatal(1, "watchdog");
  end

  // Reference frame: random words, length header, mod-256 checksum.
  task automatic build_frame(input int n, input bit bad_chk);
    logic [7:0]  s;
    logic [15:0] nn;
    logic [7:0]  b;
    nn = 16'(n);
    frm = {};
    frm.push_back(nn[7:0]);
    frm.push_back(nn[15:8]);
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      frm.push_back(b);
    end
    s = 8'h00;
    foreach (frm[i]) s = s + frm[i];
    if (bad_chk) s = s ^ 8'(1 + $urandom_range(0, 254));
    frm.push_back(s);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    logic rdy;
    bus.i_byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      rdy = bus.o_byte_ready;
      @(posedge clk);
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.i_byte_valid = 1'b0;
  endtask

  // Sends frm[first..last-1]; a completed high byte queues its expected write.
  task automatic send_frame(input int first, input int last, input int maxgap,
                            input int gap_at, input int gap_val);
    bit ok;
    int n;
    int gap;
    n = int'({frm[1], frm[0]});
    for (int i = first; i < last; i++) begin
      gap = (i == gap_at) ? gap_val : ((maxgap > 0) ? $urandom_range(0, maxgap) : 0);
      if (i >= 3 && (i % 2) == 1 && i <= 2 * n + 1)
        exp_q.push_back('{addr: BASE + 16'(i - 3), data: {frm[i], frm[i-1]}});
      send_byte(frm[i], gap, ok);
      if (!ok) begin
        check("byte_accepted", 32'(0), 32'(1));
        break;
      end
    end
  endtask

  task automatic check_end(input bit exp_done, input string tag);
    check({tag, "_done"},    32'(done),             32'(exp_done));
    check({tag, "_error"},   32'(error),            32'(!exp_done));
    check({tag, "_cpu_rst"}, 32'(cpu_rst),          32'(!exp_done));
    check({tag, "_ready"},   32'(bus.o_byte_ready), 32'(0));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'(0));
    exp_q = {};
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_done",    32'(done),             32'(0));
    check("restart_error",   32'(error),            32'(0));
    check("restart_cpu_rst", 32'(cpu_rst),          32'(1));
    check("restart_ready",   32'(bus.o_byte_ready), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   32'(bus.o_byte_ready), 32'(0));
    check({tag, "_wen"},     32'(bus.o_imem_wen),   32'(0));
    check({tag, "_addr"},    32'(bus.o_imem_addr),  32'(BASE));
    check({tag, "_data"},    32'(bus.o_imem_data),  32'(0));
    check({tag, "_cpu_rst"}, 32'(cpu_rst),          32'(1));
    check({tag, "_done"},    32'(done),             32'(0));
    check({tag, "_error"},   32'(error),            32'(0));
  endtask

  // Async reset pulse starting away from the clock edges.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    exp_q = {};
    @(negedge clk);
    rst_n = 1'b1;
    #1 check({tag, "_ready_held"}, 32'(bus.o_byte_ready), 32'(0));
    @(negedge clk);
    check({tag, "_ready_rise"}, 32'(bus.o_byte_ready), 32'(1));
  endtask

  initial begin
    int  n, k, sel;
    bit  bad, exp_ok;
    logic [7:0] s;

    bus.i_byte       = 8'h00;
    bus.i_byte_valid = 1'b0;

    @(negedge clk);
    async_reset("reset");

    // 1: nominal two-word image, back to back.
    frm = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
    send_frame(0, 7, 0, -1, 0);
    check_end(1'b1, "image");
    pulse_restart();

    // 2: same image with a wrong checksum; words still written.
    frm = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h17};
    send_frame(0, 7, 0, -1, 0);
    check_end(1'b0, "badchk");
    pulse_restart();

    // 3: zero and oversize length headers.
    frm = {8'h00, 8'h00};
    send_frame(0, 2, 0, -1, 0);
    check_end(1'b0, "len0");
    pulse_restart();
    frm = {8'(MAXW + 1), 8'h00};
    send_frame(0, 2, 0, -1, 0);
    check_end(1'b0, "lenmax1");
    pulse_restart();

    // 4: timeout after 16 idle cycles; 15 idle cycles are tolerated.
    frm = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
    send_frame(0, 3, 0, -1, 0);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_not_yet", 32'(error), 32'(0));
    @(negedge clk);
    check_end(1'b0, "timeout");
    pulse_restart();
    send_frame(0, 7, 0, 3, TMO - 1);
    check_end(1'b1, "gap15");
    pulse_restart();

    // 5: restart pulse mid-frame is ignored.
    send_frame(0, 3, 0, -1, 0);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    send_frame(3, 7, 0, -1, 0);
    check_end(1'b1, "midrestart");
    pulse_restart();

    // 6: random frames, random valid gaps, checksum faults and async aborts.
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 7);
      n   = (it == 0) ? MAXW : $urandom_range(1, MAXW);
      bad = (sel == 1) || (sel == 2);
      if (sel == 3) n = MAXW + 1;
      build_frame(n, bad);
      if (sel >= 6) begin
        k = $urandom_range(1, 2 * n + 2);
        send_frame(0, k, 4, -1, 0);
        @(negedge clk);
        async_reset("abort");
      end else begin
        exp_ok = (n >= 1) && (n <= MAXW);
        if (exp_ok) begin
          s = 8'h00;
          for (int i = 0; i < 2 * n + 2; i++) s = s + frm[i];
          exp_ok = (s == frm[2*n+2]);
          send_frame(0, 2 * n + 3, 4, -1, 0);
        end else begin
          send_frame(0, 2, 4, -1, 0);
        end
        check_end(exp_ok, "rand");
        pulse_restart();
      end
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
